// File: rtl/ram_writer.sv
// ram_writer: commits single 16-bit words to DDR3 as masked BL8 writes via the MIG app interface
module ram_writer #(
  parameter int ADDR_WIDTH = 27,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] MAX_RAM_ADDRESS = 'h03FFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     write_address,
  input  logic [15:0]               write_data,
  input  logic                      write_valid,
  output logic                      write_ready,
  output logic                      write_done,
  output logic                      addr_error,
  output logic [ADDR_WIDTH-1:0]     ram_address,
  output logic [2:0]                ram_cmd,
  output logic                      ram_en,
  input  logic                      ram_rdy,
  output logic [APP_DATA_WIDTH-1:0] ram_wdf_data,
  output logic [APP_MASK_WIDTH-1:0] ram_wdf_mask,
  output logic                      ram_wdf_wren,
  output logic                      ram_wdf_end,
  input  logic                      ram_wdf_rdy
);
  localparam logic [2:0] IDLE = 3'd0, WDF0 = 3'd1, WDF1 = 3'd2, CMD = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic live;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0] word;
  logic sel;
  // request FSM; live keeps write_ready low until the first edge after reset releases
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      live <= 1'b0;
      addr <= '0;
      word <= '0;
      addr_error <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: if (write_valid && write_ready) begin
          addr <= write_address;
          word <= write_data;
          if (write_address > MAX_RAM_ADDRESS) begin
            addr_error <= 1'b1;
            state <= DONE;
          end else state <= WDF0;
        end
        WDF0: if (ram_wdf_rdy) state <= WDF1;
        WDF1: if (ram_wdf_rdy) state <= CMD;
        CMD: if (ram_rdy) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  // outputs decode from state and latched request only; the word lands in beat addr[2], lane addr[1:0]
  always_comb begin
    sel = (state == WDF0 || state == WDF1) && (addr[2] == (state == WDF1));
    write_ready = live && state == IDLE;
    write_done = state == DONE;
    ram_address = {addr[ADDR_WIDTH-1:3], 3'b000};
    ram_cmd = 3'b000;
    ram_en = state == CMD;
    ram_wdf_wren = state == WDF0 || state == WDF1;
    ram_wdf_end = state == WDF1;
    ram_wdf_data = sel ? APP_DATA_WIDTH'(word) << {addr[1:0], 4'b0000} : '0;
    ram_wdf_mask = sel ? ~(APP_MASK_WIDTH'(2'b11) << {addr[1:0], 1'b0}) : '1;
  end
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed checks of ram_writer handshakes, beat/mask mapping, stalls, range errors and reset
module tb_ram_writer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [26:0] write_address = '0;
  logic [15:0] write_data = '0;
  logic write_valid = 1'b0;
  logic write_ready, write_done, addr_error;
  logic [26:0] ram_address;
  logic [2:0] ram_cmd;
  logic ram_en;
  logic ram_rdy = 1'b1;
  logic [63:0] ram_wdf_data;
  logic [7:0] ram_wdf_mask;
  logic ram_wdf_wren, ram_wdf_end;
  logic ram_wdf_rdy = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wren = 0, n_en = 0, n_done = 0, n_acc = 0;
  int acc_cyc [0:63];

  ram_writer dut (
    .clk(clk), .reset(reset),
    .write_address(write_address), .write_data(write_data),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_done(write_done), .addr_error(addr_error),
    .ram_address(ram_address), .ram_cmd(ram_cmd), .ram_en(ram_en), .ram_rdy(ram_rdy),
    .ram_wdf_data(ram_wdf_data), .ram_wdf_mask(ram_wdf_mask),
    .ram_wdf_wren(ram_wdf_wren), .ram_wdf_end(ram_wdf_end), .ram_wdf_rdy(ram_wdf_rdy)
  );

  always #5 clk = ~clk;

  // handshake and pulse counters sampled at each rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wdf_wren && ram_wdf_rdy) n_wren <= n_wren + 1;
    if (ram_en && ram_rdy) n_en <= n_en + 1;
    if (write_done) n_done <= n_done + 1;
    if (write_valid && write_ready) begin
      acc_cyc[n_acc % 64] <= cyc;
      n_acc <= n_acc + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int w0, e0, d0, a0;
    logic seen;
    // reset held: reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", write_ready, 0);
    chk("rst_done", write_done, 0);
    chk("rst_err", addr_error, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_wren", ram_wdf_wren, 0);
    chk("rst_end", ram_wdf_end, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_wdf_data, 0);
    chk("rst_mask", ram_wdf_mask, 8'hFF);
    chk("rst_cmd", ram_cmd, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", write_ready, 1);

    // word 5: beat 1, lane 1
    write_address = 27'h000005; write_data = 16'hBEEF; write_valid = 1'b1;
    @(negedge clk); write_valid = 1'b0;
    chk("t1_c1_wren", ram_wdf_wren, 1);
    chk("t1_c1_end", ram_wdf_end, 0);
    chk("t1_c1_data", ram_wdf_data, 0);
    chk("t1_c1_mask", ram_wdf_mask, 8'hFF);
    chk("t1_c1_en", ram_en, 0);
    @(negedge clk);
    chk("t1_c2_wren", ram_wdf_wren, 1);
    chk("t1_c2_end", ram_wdf_end, 1);
    chk("t1_c2_data", ram_wdf_data, 64'h0000_0000_BEEF_0000);
    chk("t1_c2_mask", ram_wdf_mask, 8'hF3);
    chk("t1_c2_en", ram_en, 0);
    @(negedge clk);
    chk("t1_c3_en", ram_en, 1);
    chk("t1_c3_addr", ram_address, 0);
    chk("t1_c3_wren", ram_wdf_wren, 0);
    chk("t1_c3_done", write_done, 0);
    @(negedge clk);
    chk("t1_c4_done", write_done, 1);
    chk("t1_c4_en", ram_en, 0);
    @(negedge clk);
    chk("t1_c5_done", write_done, 0);
    chk("t1_c5_ready", write_ready, 1);

    // word 0xB: beat 0, lane 3
    write_address = 27'h00000B; write_data = 16'h1234; write_valid = 1'b1;
    @(negedge clk); write_valid = 1'b0;
    chk("t2_c1_data", ram_wdf_data, 64'h1234_0000_0000_0000);
    chk("t2_c1_mask", ram_wdf_mask, 8'h3F);
    @(negedge clk);
    chk("t2_c2_data", ram_wdf_data, 0);
    chk("t2_c2_mask", ram_wdf_mask, 8'hFF);
    chk("t2_c2_end", ram_wdf_end, 1);
    @(negedge clk);
    chk("t2_c3_addr", ram_address, 27'h8);
    chk("t2_c3_en", ram_en, 1);
    @(negedge clk);
    chk("t2_c4_done", write_done, 1);
    @(negedge clk);

    // word 0x12: beat 0, lane 2; wdf_rdy low cycles 1-3, ram_rdy low cycles 6-7
    w0 = n_wren; e0 = n_en;
    write_address = 27'h000012; write_data = 16'hA5A5; write_valid = 1'b1; ram_wdf_rdy = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      write_valid = 1'b0;
      ram_wdf_rdy = (k >= 4);
      ram_rdy = !(k == 6 || k == 7);
      chk($sformatf("t3_c%0d_wren", k), ram_wdf_wren, k <= 5);
      chk($sformatf("t3_c%0d_end", k), ram_wdf_end, k == 5);
      chk($sformatf("t3_c%0d_en", k), ram_en, k >= 6 && k <= 8);
      chk($sformatf("t3_c%0d_done", k), write_done, k == 9);
      chk($sformatf("t3_c%0d_data", k), ram_wdf_data, k <= 4 ? 64'h0000_A5A5_0000_0000 : 64'h0);
      chk($sformatf("t3_c%0d_mask", k), ram_wdf_mask, k <= 4 ? 8'hCF : 8'hFF);
      if (k >= 6 && k <= 8) chk($sformatf("t3_c%0d_addr", k), ram_address, 27'h10);
    end
    chk("t3_wren_hs", n_wren - w0, 2);
    chk("t3_en_hs", n_en - e0, 1);
    @(negedge clk);
    chk("t3_ready", write_ready, 1);

    // out-of-range request
    w0 = n_wren; e0 = n_en;
    write_address = 27'h040000; write_data = 16'hDEAD; write_valid = 1'b1;
    @(negedge clk); write_valid = 1'b0;
    chk("t4_done", write_done, 1);
    chk("t4_err", addr_error, 1);
    chk("t4_wren", ram_wdf_wren, 0);
    chk("t4_en", ram_en, 0);
    @(negedge clk);
    chk("t4_ready", write_ready, 1);
    chk("t4_no_wren", n_wren - w0, 0);
    chk("t4_no_en", n_en - e0, 0);
    write_address = 27'h000000; write_data = 16'h0001; write_valid = 1'b1;
    @(negedge clk); write_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = write_done;
    end
    chk("t4_follow_done", seen, 1);
    chk("t4_err_sticky", addr_error, 1);
    chk("t4_follow_wren", n_wren - w0, 2);
    @(negedge clk);

    // back-to-back requests with write_valid held high
    a0 = n_acc; d0 = n_done;
    write_address = 27'h000020; write_data = 16'h5555; write_valid = 1'b1;
    repeat (11) @(negedge clk);
    write_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_accepts", n_acc - a0, 3);
    chk("t5_gap1", acc_cyc[(a0 + 1) % 64] - acc_cyc[a0 % 64], 5);
    chk("t5_gap2", acc_cyc[(a0 + 2) % 64] - acc_cyc[(a0 + 1) % 64], 5);
    chk("t5_dones", n_done - d0, 3);
    chk("t5_ready", write_ready, 1);

    // asynchronous reset in WDF1
    write_address = 27'h000005; write_data = 16'hBEEF; write_valid = 1'b1;
    @(negedge clk); write_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_wdf1", ram_wdf_end, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_ready", write_ready, 0);
    chk("t6_wren", ram_wdf_wren, 0);
    chk("t6_end", ram_wdf_end, 0);
    chk("t6_en", ram_en, 0);
    chk("t6_data", ram_wdf_data, 0);
    chk("t6_mask", ram_wdf_mask, 8'hFF);
    chk("t6_addr", ram_address, 0);
    chk("t6_err", addr_error, 0);
    d0 = n_done;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t6_rel_ready", write_ready, 1);
    repeat (6) @(negedge clk);
    chk("t6_no_done", n_done - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
